// File: rtl/afifo_pkg.sv
// Shared async-FIFO definitions used by both the write- and read-side pointer controllers.
// Pointer helpers work on the widest legal pointer; narrower pointers are zero-extended.
package afifo_pkg;
   localparam int AFIFO_SYNC_STAGES = 2;
   localparam int AFIFO_ADDR_W_MIN  = 2;
   localparam int AFIFO_ADDR_W_MAX  = 12;
   localparam int AFIFO_PTR_W_MAX   = AFIFO_ADDR_W_MAX + 1;

   typedef logic [AFIFO_PTR_W_MAX-1:0] afifo_ptr_t;

   function automatic afifo_ptr_t bin2gray(input afifo_ptr_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Leading zeros of a zero-extended pointer leave the XOR prefix unchanged.
   function automatic afifo_ptr_t gray2bin(input afifo_ptr_t gray);
      afifo_ptr_t bin;
      bin[AFIFO_PTR_W_MAX-1] = gray[AFIFO_PTR_W_MAX-1];
      for (int i = AFIFO_PTR_W_MAX - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction
endpackage

// File: rtl/afifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down), zero latency.
module afifo_gray2bin #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end
endmodule

// File: rtl/afifo_wptr_ctrl.sv
// Async FIFO write-side pointer/flag controller: Gray/binary pointers, full, level, almost-full.
// Flags register one wclk after a push or rptr_wclk change; sticky overflow only with AFIFO_WOVF_EN.
module afifo_wptr_ctrl
   import afifo_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              wclk,
   input  logic              wrst_n,
   input  logic              wpush,
   input  logic [ADDR_W:0]   rptr_wclk,
   input  logic [ADDR_W:0]   wafull_thr,
   input  logic              wovf_clr,
   output logic [ADDR_W-1:0] waddr,
   output logic              wen,
   output logic [ADDR_W:0]   wptr,
   output logic              wfull,
   output logic              walmost_full,
   output logic [ADDR_W:0]   wlevel,
   output logic              wovf
);
   if (ADDR_W < AFIFO_ADDR_W_MIN || ADDR_W > AFIFO_ADDR_W_MAX) begin : g_bad_addr_w
      $error("afifo_wptr_ctrl: ADDR_W=%0d outside legal range 2..12", ADDR_W);
   end

   logic [ADDR_W:0] wbin;
   logic [ADDR_W:0] wbin_next;
   logic [ADDR_W:0] wptr_next;
   logic [ADDR_W:0] rbin_wclk;
   logic [ADDR_W:0] lvl_next;
   logic            full_next;

   assign wen       = wpush & ~wfull;
   assign waddr     = wbin[ADDR_W-1:0];
   assign wbin_next = wbin + {{ADDR_W{1'b0}}, wen};
   assign wptr_next = (wbin_next >> 1) ^ wbin_next;

   afifo_gray2bin #(.W(ADDR_W + 1)) u_rptr_g2b (
      .gray (rptr_wclk),
      .bin  (rbin_wclk)
   );

   // Level uses the lagging synchronised read pointer, so it can only over-report.
   assign lvl_next  = wbin_next - rbin_wclk;
   assign full_next = (wptr_next == {~rptr_wclk[ADDR_W:ADDR_W-1], rptr_wclk[ADDR_W-2:0]});

`ifndef AFIFO_WOVF_EN
   logic unused_wovf_clr;
   assign unused_wovf_clr = wovf_clr;
   assign wovf            = 1'b0;
`endif

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
`ifdef AFIFO_WOVF_EN
         wovf         <= 1'b0;
`endif
      end else begin
         wbin         <= wbin_next;
         wptr         <= wptr_next;
         wfull        <= full_next;
         walmost_full <= (lvl_next >= wafull_thr);
         wlevel       <= lvl_next;
`ifdef AFIFO_WOVF_EN
         // Set has priority over a coincident clear.
         if (wpush && wfull) begin
            wovf <= 1'b1;
         end else if (wovf_clr) begin
            wovf <= 1'b0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_afifo_wptr_ctrl.sv
// Self-checking bench for afifo_wptr_ctrl (ADDR_W=4): vector table, directed corners, random vs model.
module tb_afifo_wptr_ctrl;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
`ifdef AFIFO_WOVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic              wclk = 1'b0;
   logic              wrst_n;
   logic              wpush;
   logic [ADDR_W:0]   rptr_wclk;
   logic [ADDR_W:0]   wafull_thr;
   logic              wovf_clr;
   logic [ADDR_W-1:0] waddr;
   logic              wen;
   logic [ADDR_W:0]   wptr;
   logic              wfull;
   logic              walmost_full;
   logic [ADDR_W:0]   wlevel;
   logic              wovf;

   afifo_wptr_ctrl #(.ADDR_W(ADDR_W)) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .wpush        (wpush),
      .rptr_wclk    (rptr_wclk),
      .wafull_thr   (wafull_thr),
      .wovf_clr     (wovf_clr),
      .waddr        (waddr),
      .wen          (wen),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .wovf         (wovf)
   );

   always #5 wclk = ~wclk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: counts of accepted writes and of reads seen by the write side.
   int m_wcnt;
   int m_rcnt;
   int m_lvl;
   bit m_full;
   bit m_afull;
   bit m_ovf;

   typedef struct {
      bit push;
      int rcnt;
      int thr;
      bit exp_wen;
      int exp_waddr;
      int exp_lvl;
      bit exp_full;
      bit exp_afull;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [ADDR_W:0] gray5(input int b);
      logic [ADDR_W:0] x;
      x = b[ADDR_W:0];
      return x ^ (x >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_wcnt = 0; m_rcnt = 0; m_lvl = 0;
      m_full = 0; m_afull = 0; m_ovf = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_waddr"}, int'(waddr), 0);
      chk({tag, "_wptr"}, int'(wptr), 0);
      chk({tag, "_wfull"}, int'(wfull), 0);
      chk({tag, "_wafull"}, int'(walmost_full), 0);
      chk({tag, "_wlevel"}, int'(wlevel), 0);
      chk({tag, "_wovf"}, int'(wovf), 0);
   endtask

   // Called just after a negedge; returns just after the following negedge.
   task automatic do_reset(input int thr);
      wrst_n = 1'b0; wpush = 1'b0; wovf_clr = 1'b0;
      rptr_wclk = '0; wafull_thr = thr[ADDR_W:0];
      #3;
      check_all_zero("reset");
      @(negedge wclk);
      wrst_n = 1'b1;
      model_reset();
   endtask

   task automatic apply(input bit push, input int rcnt, input int thr, input bit clr);
      wpush = push; rptr_wclk = gray5(rcnt); wafull_thr = thr[ADDR_W:0]; wovf_clr = clr;
      m_rcnt = rcnt;
      #1;
      chk("wen", int'(wen), int'(push && !m_full));
      chk("waddr", int'(waddr), m_wcnt % DEPTH);
      @(posedge wclk);
      #1;
      if (OVF_EN) begin
         if (push && m_full) m_ovf = 1;
         else if (clr) m_ovf = 0;
      end
      if (push && !m_full) m_wcnt++;
      m_lvl   = m_wcnt - rcnt;
      m_full  = (m_lvl == DEPTH);
      m_afull = (m_lvl >= thr);
      chk("wlevel", int'(wlevel), m_lvl);
      chk("wfull", int'(wfull), int'(m_full));
      chk("walmost_full", int'(walmost_full), int'(m_afull));
      chk("wptr", int'(wptr), int'(gray5(m_wcnt)));
      chk("wovf", int'(wovf), int'(m_ovf));
      @(negedge wclk);
   endtask

   initial begin
      vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 1};
      vecs[1] = '{0, 0, 5, 0, 0, 0, 0, 0};
      vecs[2] = '{1, 0, 5, 1, 0, 1, 0, 0};
      vecs[3] = '{1, 0, 5, 1, 1, 2, 0, 0};
      vecs[4] = '{1, 0, 5, 1, 2, 3, 0, 0};
      vecs[5] = '{1, 0, 5, 1, 3, 4, 0, 0};
      vecs[6] = '{1, 0, 5, 1, 4, 5, 0, 1};
      vecs[7] = '{0, 1, 5, 0, 5, 4, 0, 0};
      vecs[8] = '{1, 1, 4, 1, 5, 5, 0, 1};

      wrst_n = 1'b0; wpush = 1'b0; wovf_clr = 1'b0; rptr_wclk = '0; wafull_thr = '0;
      @(negedge wclk);

      // Threshold table (thr=0 sets the flag on the first edge after release).
      do_reset(0);
      foreach (vecs[i]) begin
         wpush = vecs[i].push; rptr_wclk = gray5(vecs[i].rcnt);
         wafull_thr = vecs[i].thr[ADDR_W:0]; wovf_clr = 1'b0;
         #1;
         chk($sformatf("vec%0d_wen", i), int'(wen), int'(vecs[i].exp_wen));
         chk($sformatf("vec%0d_waddr", i), int'(waddr), vecs[i].exp_waddr);
         @(posedge wclk);
         #1;
         chk($sformatf("vec%0d_wlevel", i), int'(wlevel), vecs[i].exp_lvl);
         chk($sformatf("vec%0d_wfull", i), int'(wfull), int'(vecs[i].exp_full));
         chk($sformatf("vec%0d_wafull", i), int'(walmost_full), int'(vecs[i].exp_afull));
         @(negedge wclk);
      end

      // Fill to full, then push while full.
      do_reset(14);
      for (int i = 0; i < DEPTH; i++) begin
         apply(1, 0, 14, 0);
         if (i == 12) chk("fill13_wafull", int'(walmost_full), 0);
         if (i == 13) chk("fill14_wafull", int'(walmost_full), 1);
      end
      chk("fill_wptr", int'(wptr), 5'b11000);
      chk("fill_wlevel", int'(wlevel), DEPTH);
      chk("fill_wfull", int'(wfull), 1);
      apply(1, 0, 14, 0);
      chk("ovf_push_wptr", int'(wptr), 5'b11000);
      chk("ovf_set", int'(wovf), int'(OVF_EN));

      // Clear coinciding with another push-while-full loses; clear alone wins.
      apply(1, 0, 14, 1);
      chk("ovf_set_wins", int'(wovf), int'(OVF_EN));
      apply(0, 0, 14, 1);
      chk("ovf_clr", int'(wovf), 0);

      // Push in the same cycle the read pointer advances: still rejected.
      apply(1, 1, 14, 0);
      chk("simul_wfull", int'(wfull), 0);
      chk("simul_wlevel", int'(wlevel), 15);

      // Drain completely, then refill through the address wrap.
      apply(0, 16, 14, 0);
      chk("drain_wlevel", int'(wlevel), 0);
      chk("drain_wfull", int'(wfull), 0);
      for (int i = 0; i < DEPTH; i++) apply(1, 16, 14, 0);
      chk("wrap_wptr", int'(wptr), 0);
      chk("wrap_wfull", int'(wfull), 1);
      chk("wrap_waddr", int'(waddr), 0);

      // Async reset between edges, mid-burst.
      do_reset(14);
      for (int i = 0; i < 9; i++) apply(1, 0, 14, 0);
      chk("pre_arst_waddr", int'(waddr), 9);
      wpush = 1'b1;
      #2;
      wrst_n = 1'b0;
      #1;
      check_all_zero("arst");
      wpush = 1'b0;
      @(negedge wclk);
      wrst_n = 1'b1;
      model_reset();
      apply(1, 0, 14, 0);
      chk("arst_resume_waddr", int'(waddr), 1);

      // Randomised traffic against the model.
      begin
         int thr;
         int r;
         thr = 10;
         do_reset(thr);
         for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) thr = $urandom_range(0, DEPTH);
            r = m_rcnt;
            if (r < m_wcnt && $urandom_range(0, 2) == 0) r++;
            apply($urandom_range(0, 3) != 0, r, thr, $urandom_range(0, 7) == 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
